// File: rtl/fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with registered head, any DEPTH >= 2.
// Optional high-water mark tracking is enabled by defining FIFO_HWM_EN.
module fifo_fwft #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          flush_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          full_o,
  output logic          m_valid_o,
  output logic [DW-1:0] m_data_o,
  input  logic          m_ready_i,
  output logic [CW-1:0] count_o,
  input  logic [CW-1:0] afull_thr_i,
  input  logic [CW-1:0] aempty_thr_i,
  output logic          afull_o,
  output logic          aempty_o,
  output logic          overflow_o,
  input  logic          err_clr_i,
  output logic [CW-1:0] hwm_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_inc, rd_ptr_inc;
  logic [CW-1:0] count;
  logic [DW-1:0] head_data, head_next;
  logic          overflow;
  logic          wr_acc, rd_acc;

  assign full_o     = (count == CW'(DEPTH));
  assign m_valid_o  = (count != '0);
  assign m_data_o   = head_data;
  assign count_o    = count;
  assign overflow_o = overflow;
  assign afull_o    = (count >= afull_thr_i);
  assign aempty_o   = (count <= aempty_thr_i);

  assign wr_acc = wr_en_i & ~full_o & ~flush_i;
  assign rd_acc = m_valid_o & m_ready_i & ~flush_i;

  // Explicit wrap so non-power-of-two depths work.
  assign wr_ptr_inc = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
  assign rd_ptr_inc = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  // mem[rd_ptr] always mirrors the head register; bypass write data when the FIFO runs dry.
  always_comb begin
    head_next = head_data;
    if (wr_acc && ((count == '0) || (rd_acc && (count == CW'(1))))) begin
      head_next = wr_data_i;
    end else if (rd_acc && (count >= CW'(2))) begin
      head_next = mem[rd_ptr_inc];
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_data <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr_inc;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr_inc;
      end
      count     <= count + {{(CW-1){1'b0}}, wr_acc} - {{(CW-1){1'b0}}, rd_acc};
      head_data <= head_next;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      overflow <= 1'b0;
    end else begin
      overflow <= (wr_en_i & full_o & ~flush_i) | (overflow & ~err_clr_i);
    end
  end

`ifdef FIFO_HWM_EN
  logic [CW-1:0] hwm;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hwm <= '0;
    end else if (err_clr_i) begin
      hwm <= count;
    end else if (count > hwm) begin
      hwm <= count;
    end
  end

  assign hwm_o = hwm;
`else
  assign hwm_o = '0;
`endif

endmodule
